// File: rtl/prog_clk_div_pkg.sv
// Shared constants and the high-time clamp rule for the programmable clock divider.
package prog_clk_div_pkg;

    localparam int MIN_DIV = 2;

    // Widest legal field; callers widen to this and narrow the result back.
    function automatic logic [15:0] clamp_high(input logic [15:0] div, input logic [15:0] high);
        if (high == 16'd0) return 16'd1;
        if (high >= div)   return div - 16'd1;
        return high;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow settings and registered outputs.
module clk_div_chan
    import prog_clk_div_pkg::*;
#(
    parameter int CW       = 8,
    parameter int DEF_DIV  = 7,
    parameter int DEF_HIGH = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_wr,
    input  logic [CW-1:0] i_wr_div,
    input  logic [CW-1:0] i_wr_high,
    output logic          o_pend,
    output logic          o_clk,
    output logic          o_tick
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] sdiv_q, sdiv_d;
    logic [CW-1:0] shigh_q, shigh_d;
    logic          pend_q, pend_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic [CW-1:0] wr_high_c;
    logic          wrap;

    assign wr_high_c = CW'(clamp_high(16'(i_wr_div), 16'(i_wr_high)));
    assign wrap      = (cnt_q == div_q - ONE);

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
        cnt_d   = cnt_q;
        div_d   = div_q;
        high_d  = high_q;
        sdiv_d  = sdiv_q;
        shigh_d = shigh_q;
        pend_d  = pend_q;
        clk_d   = i_en && (cnt_q < high_q);
        tick_d  = i_en && (cnt_q == '0);

        if (i_en) begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
            // Swapping settings only at the period boundary keeps o_clk glitch-free.
            if (wrap && pend_q) begin
                div_d  = sdiv_q;
                high_d = shigh_q;
                pend_d = 1'b0;
            end
        end else begin
            cnt_d = '0;
            if (pend_q) begin
                div_d  = sdiv_q;
                high_d = shigh_q;
                pend_d = 1'b0;
            end
        end

        // The top only writes when pend_q is clear, so this never collides with the swap.
        if (i_wr) begin
            if (i_en) begin
                sdiv_d  = i_wr_div;
                shigh_d = wr_high_c;
                pend_d  = 1'b1;
            end else begin
                div_d  = i_wr_div;
                high_d = wr_high_c;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            cnt_q   <= '0;
            div_q   <= CW'(DEF_DIV);
            high_q  <= CW'(DEF_HIGH);
            sdiv_q  <= '0;
            shigh_q <= '0;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            sdiv_q  <= sdiv_d;
            shigh_q <= shigh_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign o_pend = pend_q;
    assign o_clk  = clk_q;
    assign o_tick = tick_q;

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider with a shared configuration port.
module prog_clk_div
    import prog_clk_div_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CW       = 8,
    parameter int DEF_DIV  = 7,
    parameter int DEF_HIGH = 3,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [NCH-1:0] i_en,
    input  logic           i_cfg_valid,
    output logic           o_cfg_ready,
    input  logic [CHW-1:0] i_cfg_ch,
    input  logic [CW-1:0]  i_cfg_div,
    input  logic [CW-1:0]  i_cfg_high,
    output logic           o_cfg_err,
    output logic [NCH-1:0] o_clk,
    output logic [NCH-1:0] o_tick
);

    logic [NCH-1:0] pend;
    logic [NCH-1:0] wr;
    logic           cfg_ready;
    logic           accept;
    logic           bad_div;
    logic           err_q, err_d;

    // Channel indices beyond NCH match no entry and so stay not-ready.
    always_comb begin
        cfg_ready = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            if (i_cfg_ch == CHW'(n)) cfg_ready = !pend[n];
        end
    end

    assign o_cfg_ready = cfg_ready;
    assign accept      = i_cfg_valid && cfg_ready && !i_rst;
    assign bad_div     = (i_cfg_div < CW'(MIN_DIV));
    assign err_d       = accept && bad_div;

    always_comb begin
        wr = '0;
        for (int n = 0; n < NCH; n++) begin
            wr[n] = accept && !bad_div && (i_cfg_ch == CHW'(n));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign o_cfg_err = err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .CW       (CW),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (i_en[g]),
            .i_wr      (wr[g]),
            .i_wr_div  (i_cfg_div),
            .i_wr_high (i_cfg_high),
            .o_pend    (pend[g]),
            .o_clk     (o_clk[g]),
            .o_tick    (o_tick[g])
        );
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Scoreboard bench for prog_clk_div: a period-pattern reference model predicts every output cycle.
module tb_prog_clk_div;

    localparam int NCH      = 3;
    localparam int CW       = 8;
    localparam int DEF_DIV  = 7;
    localparam int DEF_HIGH = 3;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [NCH-1:0] i_en;
    logic           i_cfg_valid;
    logic           o_cfg_ready;
    logic [1:0]     i_cfg_ch;
    logic [CW-1:0]  i_cfg_div;
    logic [CW-1:0]  i_cfg_high;
    logic           o_cfg_err;
    logic [NCH-1:0] o_clk;
    logic [NCH-1:0] o_tick;

    prog_clk_div #(
        .NCH      (NCH),
        .CW       (CW),
        .DEF_DIV  (DEF_DIV),
        .DEF_HIGH (DEF_HIGH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_ch    (i_cfg_ch),
        .i_cfg_div   (i_cfg_div),
        .i_cfg_high  (i_cfg_high),
        .o_cfg_err   (o_cfg_err),
        .o_clk       (o_clk),
        .o_tick      (o_tick)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit           chk;
        bit           chk_rdy;
        bit           rdy;
        bit [NCH-1:0] clk;
        bit [NCH-1:0] tick;
        bit           err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: each enabled channel replays a queued whole-period waveform.
    int           m_div[NCH], m_high[NCH], m_sdiv[NCH], m_shigh[NCH];
    bit           m_pend[NCH];
    bit [1:0]     m_pat[NCH][$];
    bit [NCH-1:0] m_clk, m_tick;
    bit           m_err;
    bit           m_known = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int div, input int high);
        if (high == 0) return 1;
        if (high >= div) return div - 1;
        return high;
    endfunction

    function automatic bit pend_of(input int ch);
        if (ch >= NCH) return 1'b1;
        return m_pend[ch];
    endfunction

    task automatic apply_shadow(input int n);
        m_div[n]  = m_sdiv[n];
        m_high[n] = m_shigh[n];
        m_pend[n] = 1'b0;
    endtask

    task automatic model_step(input bit rst, input bit [NCH-1:0] en, input bit v,
                              input int ch, input int div, input int high);
        bit       acc;
        bit [1:0] p;
        if (rst) begin
            for (int n = 0; n < NCH; n++) begin
                m_div[n]  = DEF_DIV;
                m_high[n] = DEF_HIGH;
                m_pend[n] = 1'b0;
                m_pat[n].delete();
            end
            m_clk   = '0;
            m_tick  = '0;
            m_err   = 1'b0;
            m_known = 1'b1;
            return;
        end
        acc = v && !pend_of(ch);
        for (int n = 0; n < NCH; n++) begin
            if (en[n]) begin
                if (m_pat[n].size() == 0) begin
                    for (int k = 0; k < m_div[n]; k++) m_pat[n].push_back({k < m_high[n], k == 0});
                end
                p         = m_pat[n].pop_front();
                m_clk[n]  = p[1];
                m_tick[n] = p[0];
                if (m_pat[n].size() == 0 && m_pend[n]) apply_shadow(n);
            end else begin
                m_pat[n].delete();
                m_clk[n]  = 1'b0;
                m_tick[n] = 1'b0;
                if (m_pend[n]) apply_shadow(n);
            end
        end
        m_err = acc && (div < 2);
        if (acc && div >= 2) begin
            if (en[ch]) begin
                m_sdiv[ch]  = div;
                m_shigh[ch] = clamp(div, high);
                m_pend[ch]  = 1'b1;
            end else begin
                m_div[ch]  = div;
                m_high[ch] = clamp(div, high);
            end
        end
    endtask

    // Drive one cycle, queue what the DUT must show during it, then advance the model at the edge.
    task automatic cycle(input bit rst, input bit [NCH-1:0] en, input bit v,
                         input int ch, input int div, input int high);
        exp_t e;
        i_rst       = rst;
        i_en        = en;
        i_cfg_valid = v;
        i_cfg_ch    = 2'(ch);
        i_cfg_div   = CW'(div);
        i_cfg_high  = CW'(high);
        e.chk     = m_known;
        e.chk_rdy = m_known && !rst;
        e.rdy     = !pend_of(ch);
        e.clk     = m_clk;
        e.tick    = m_tick;
        e.err     = m_err;
        exp_q.push_back(e);
        @(posedge i_clk);
        model_step(rst, en, v, ch, div, high);
        #1;
    endtask

    task automatic run(input int n, input bit [NCH-1:0] en);
        for (int i = 0; i < n; i++) cycle(1'b0, en, 1'b0, 0, 0, 0);
    endtask

    task automatic req(input bit [NCH-1:0] en, input int ch, input int div, input int high);
        cycle(1'b0, en, 1'b1, ch, div, high);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check("o_clk", 32'(o_clk), 32'(e.clk));
                    check("o_tick", 32'(o_tick), 32'(e.tick));
                    check("o_cfg_err", 32'(o_cfg_err), 32'(e.err));
                end
                if (e.chk_rdy) check("o_cfg_ready", 32'(o_cfg_ready), 32'(e.rdy));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit [NCH-1:0] en;
        i_rst = 1'b1; i_en = '0; i_cfg_valid = 1'b0; i_cfg_ch = '0; i_cfg_div = '0; i_cfg_high = '0;
        @(posedge i_clk);
        #1;
        cycle(1'b1, '0, 1'b1, 0, 5, 2);
        cycle(1'b1, '0, 1'b0, 0, 0, 0);

        run(22, 3'b001);
        req(3'b001, 0, 4, 2);
        req(3'b001, 0, 6, 1);
        req(3'b001, 0, 6, 1);
        run(16, 3'b001);

        req(3'b001, 0, 1, 1);
        run(2, 3'b001);
        req(3'b001, 0, 0, 3);
        req(3'b001, 0, 5, 9);
        run(16, 3'b001);

        req(3'b001, 1, 3, 1);
        run(2, 3'b001);
        run(14, 3'b011);

        for (int i = 0; i < 64 && m_pat[0].size() != 1; i++) run(1, 3'b011);
        req(3'b011, 0, 6, 0);
        run(18, 3'b011);

        req(3'b011, 3, 4, 2);
        req(3'b111, 2, 4, 1);
        run(2, 3'b111);
        req(3'b111, 2, 9, 4);
        run(1, 3'b011);
        run(12, 3'b111);

        req(3'b111, 0, 6, 2);
        run(2, 3'b111);
        cycle(1'b1, 3'b111, 1'b1, 1, 3, 1);
        run(16, 3'b001);

        en = 3'b101;
        for (int i = 0; i < 700; i++) begin
            for (int b = 0; b < NCH; b++) if ($urandom_range(0, 15) == 0) en[b] = ~en[b];
            cycle($urandom_range(0, 199) == 0, en, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 12));
        end
        run(4, en);

        @(negedge i_clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
- REQ-001 Parameter NCH, default 4: number of independent divider channels, legal 1..16.
- REQ-002 Parameter CW, default 8: width of the divide and high-time fields, legal 2..16.
- REQ-003 Parameter DEF_DIV, default 7: period in i_clk cycles loaded at reset.
- REQ-004 Parameter DEF_HIGH, default 3: high-time in i_clk cycles loaded at reset.
- REQ-005 Port i_clk, input, 1 bit: sole clock; all state updates on its rising edge.
- REQ-006 Port i_rst, input, 1 bit: synchronous, active-high reset.
- REQ-007 Port i_en, input, NCH bits: per-channel run enable.
- REQ-008 Port i_cfg_valid, input, 1 bit: configuration request valid.
- REQ-009 Port o_cfg_ready, output, 1 bit: configuration request can be accepted.
- REQ-010 Port i_cfg_ch, input, max(1,clog2(NCH)) bits: target channel index.
- REQ-011 Port i_cfg_div, input, CW bits: requested period in i_clk cycles.
- REQ-012 Port i_cfg_high, input, CW bits: requested high-time in i_clk cycles.
- REQ-013 Port o_cfg_err, output, 1 bit: one-cycle pulse when an accepted request is rejected.
- REQ-014 Port o_clk, output, NCH bits: registered divided clocks.
- REQ-015 Port o_tick, output, NCH bits: one-cycle pulse on the first high cycle of each period.

Function
- REQ-016 Each channel SHALL hold an active (div, high) pair and a counter cnt that runs 0..div-1 and wraps to 0.
- REQ-017 While i_en[n]=1, in period cycle k (k=0..div-1), o_clk[n] SHALL be 1 iff k<high; all outputs are registered, giving one cycle of latency from the counter.
- REQ-018 The first o_clk high cycle SHALL be the second rising edge after i_en[n] rises.
- REQ-019 o_tick[n] SHALL be 1 exactly in period cycle k=0 while the channel is enabled.
- REQ-020 When i_en[n]=0, cnt SHALL be held at 0, and o_clk[n] and o_tick[n] SHALL be 0 from the next cycle onward.
- REQ-021 A request SHALL be accepted on a cycle with i_cfg_valid=1 and o_cfg_ready=1.
- REQ-022 o_cfg_ready SHALL equal NOT pending[i_cfg_ch]; it SHALL be 0 if i_cfg_ch>=NCH.
- REQ-023 If an accepted request has i_cfg_div<2, it SHALL be discarded, and o_cfg_err SHALL pulse on the next cycle.
- REQ-024 The accepted high value SHALL be clamped: 0 becomes 1; any value >= div becomes div-1.
- REQ-025 An accepted request to a disabled channel SHALL become active on the next cycle, with no pending state.
- REQ-026 An accepted request to an enabled channel SHALL be stored in a shadow register and set pending.
- REQ-027 A pending shadow SHALL be copied to active, and pending cleared, on the wrap cycle (cnt=div-1); this keeps o_clk glitch-free.
- REQ-028 A request accepted on the wrap cycle itself SHALL apply at the following wrap, not the current one.
- REQ-029 If i_en[n] falls while pending is set, the shadow SHALL apply on the next cycle.
- REQ-030 Channels SHALL be fully independent; no ordering or throughput coupling between channels.

Reset
- REQ-031 On i_rst=1, every channel SHALL load cnt=0, div=DEF_DIV, high=DEF_HIGH, pending=0, and an empty shadow.
- REQ-032 During reset, o_clk=0, o_tick=0, o_cfg_err=0; a request presented during reset SHALL be ignored.
- REQ-033 Reset asserted mid-period or mid-pending SHALL discard all state; no partial period completes.

Structure
- REQ-034 Shared package prog_clk_div_pkg SHALL hold MIN_DIV=2 and the clamp rule function.
- REQ-035 Sub-module clk_div_chan SHALL implement one channel: counter, active/shadow registers, pending flag and outputs.
- REQ-036 The top level SHALL instantiate NCH copies via generate and add the request decode, ready mux and error pulse.

Verification
- REQ-037 Reset, i_en=1 on channel 0 -> o_clk pattern 1110000 repeating; o_tick on each first 1; period 7.
- REQ-038 Channel 0 running; write div=4, high=2 mid-period -> old 7/3 period finishes, then 1100 repeating; ready is 0 until the wrap.
- REQ-039 Write div=1 -> o_cfg_err pulse one cycle later; channel unchanged. Write div=5, high=9 -> clamped to high=4.
- REQ-040 Channel 1 disabled; write div=3, high=1, then enable -> 100 repeating from the second edge.
- REQ-041 Request on the wrap cycle -> applied one full period later. Second write while pending -> held off by ready=0.
- REQ-042 i_rst pulsed mid-period with pending set -> next enabled period is 7/3 and pending is cleared.
